wb_host_master: RTL and testbench

Single-outstanding Wishbone classic-cycle initiator that turns a valid/ready command stream into one bus transaction at a time and returns a valid/ready response. It drives the same user-project Wishbone port our peripheral responders sit on (base 32'h30000000 region), and serves as the bench and in-design master for exercising the control/status registers from local logic. Includes a bus timeout so a non-responding address cannot hang the issuer.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_timeout_ctr.sv | 36 +++
 rtl/wb_host_master.sv | 158 +++++++++++++++
 tb/tb_wb_host_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone host definitions: bus widths, FSM states
// and the default read-back value for a bus timeout.
package wb_pkg;

    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_DAT_W-1:0] WB_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating bus-cycle counter; flags the last permitted cycle
// so the host can abort without an extra cycle of latency.
module wb_timeout_ctr #(
    parameter int LIMIT = 16,
    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (LIMIT != 0) && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic initiator: one command in,
// one bus cycle, one response out, with a bounded ack wait.
module wb_host_master
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int READ_DATA_DELAY = 0,
    parameter logic [WB_DAT_W-1:0] TIMEOUT_DATA = WB_TIMEOUT_DATA
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_DAT_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_DAT_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    output logic                busy
);

    wb_state_e state_q, state_d;

    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic [WB_DAT_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic                rv_q, rv_d;
    logic [WB_DAT_W-1:0] rdat_q, rdat_d;
    logic                rerr_q, rerr_d;

    logic accept;
    logic bus_ack;
    logic expired;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign bus_ack   = (state_q == ST_BUS) && wbm_ack_i;

    wb_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i    (wb_clk_i),
        .rst_n_i  (wb_rst_n_i),
        .clr_i    (accept),
        .en_i     ((state_q == ST_BUS) && !wbm_ack_i),
        .expired_o(expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = ST_BUS;
            end
            ST_BUS: begin
                if (wbm_ack_i) begin
                    if (!we_q && (READ_DATA_DELAY != 0)) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so that
    // cyc/stb and rsp_valid change exactly at the transition edge.
    always_comb begin
        we_d   = we_q;
        sel_d  = sel_q;
        adr_d  = adr_q;
        dat_d  = dat_q;
        rdat_d = rdat_q;
        rerr_d = rerr_q;
        if (accept) begin
            we_d  = cmd_we;
            sel_d = cmd_sel;
            adr_d = cmd_adr;
            dat_d = cmd_dat;
        end
        if (bus_ack) begin
            rdat_d = we_q ? '0 : wbm_dat_i;
            rerr_d = 1'b0;
        end else if ((state_q == ST_BUS) && expired) begin
            rdat_d = TIMEOUT_DATA;
            rerr_d = 1'b1;
        end
        if (state_q == ST_CAPTURE) begin
            rdat_d = wbm_dat_i;
            rerr_d = 1'b0;
        end
        cyc_d = (state_d == ST_BUS);
        rv_d  = (state_d == ST_RESP);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
            rv_q   <= 1'b0;
            rdat_q <= '0;
            rerr_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            we_q   <= we_d;
            sel_q  <= sel_d;
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            rv_q   <= rv_d;
            rdat_q <= rdat_d;
            rerr_q <= rerr_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rv_q;
    assign rsp_dat   = rdat_q;
    assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: scripted responder, response
// scoreboard, plus a second instance with delayed read capture.
module tb_wb_host_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
    logic        busy;

    logic        d1_cmd_valid, d1_cmd_ready;
    logic        d1_rsp_valid, d1_rsp_err;
    logic [31:0] d1_rsp_dat;
    logic        d1_cyc, d1_stb, d1_we, d1_ack;
    logic [3:0]  d1_sel;
    logic [31:0] d1_adr, d1_dat_o, d1_dat_i;
    logic        d1_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    wb_host_master #(
        .TIMEOUT_CYCLES(16),
        .READ_DATA_DELAY(0),
        .TIMEOUT_DATA(32'hDEADBEEF)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb),
        .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel),
        .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack), .wbm_dat_i(wbm_dat_i),
        .busy(busy)
    );

    wb_host_master #(
        .TIMEOUT_CYCLES(8),
        .READ_DATA_DELAY(1),
        .TIMEOUT_DATA(32'hDEADBEEF)
    ) dut_d1 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready),
        .cmd_we(1'b0), .cmd_adr(32'h30000010),
        .cmd_dat(32'h0), .cmd_sel(4'hF),
        .rsp_valid(d1_rsp_valid), .rsp_ready(1'b1),
        .rsp_dat(d1_rsp_dat), .rsp_err(d1_rsp_err),
        .wbm_cyc_o(d1_cyc), .wbm_stb_o(d1_stb),
        .wbm_we_o(d1_we), .wbm_sel_o(d1_sel),
        .wbm_adr_o(d1_adr), .wbm_dat_o(d1_dat_o),
        .wbm_ack_i(d1_ack), .wbm_dat_i(d1_dat_i),
        .busy(d1_busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every handshake must match the oldest entry.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_extra", {31'd0, rsp_valid}, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_dat", rsp_dat, e[31:0]);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end
        end
    end

    task automatic drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    task automatic run_txn(input string tag,
                           input logic we,
                           input logic [31:0] adr,
                           input logic [31:0] dat,
                           input logic [3:0] sel,
                           input int ack_at,
                           input logic [31:0] rdata,
                           input logic [31:0] exp_dat,
                           input logic exp_err,
                           input int exp_cyc);
        int ncyc = 0;
        int bad = 0;
        @(negedge clk);
        chk({tag, "_rdy"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_adr = adr;
        cmd_dat = dat;
        cmd_sel = sel;
        exp_q.push_back({exp_err, exp_dat});
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wbm_cyc !== 1'b1) break;
            ncyc++;
            if (wbm_adr !== adr || wbm_dat_o !== dat ||
                wbm_we !== we || wbm_sel !== sel ||
                wbm_stb !== 1'b1) bad++;
            wbm_ack = (ncyc == ack_at);
            wbm_dat_i = rdata;
            @(negedge clk);
        end
        wbm_ack = 1'b0;
        chk({tag, "_cyc_len"}, ncyc, exp_cyc);
        chk({tag, "_bus_hold"}, bad, 32'd0);
        drain({tag, "_drain"});
    endtask

    initial begin
        int bad;
        int k;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_adr = '0;
        cmd_dat = '0;
        cmd_sel = '0;
        rsp_ready = 1'b1;
        wbm_ack = 1'b0;
        wbm_dat_i = '0;
        d1_cmd_valid = 1'b0;
        d1_ack = 1'b0;
        d1_dat_i = '0;
        repeat (3) @(negedge clk);

        chk("rst_cyc", {31'd0, wbm_cyc}, 32'd0);
        chk("rst_we", {31'd0, wbm_we}, 32'd0);
        chk("rst_sel", {28'd0, wbm_sel}, 32'd0);
        chk("rst_adr", wbm_adr, 32'd0);
        chk("rst_dat_o", wbm_dat_o, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst_n = 1'b1;

        run_txn("rd0", 1'b0, 32'h30000004, 32'h0, 4'hF,
                1, 32'h4669626F, 32'h4669626F, 1'b0, 1);
        run_txn("wr3", 1'b1, 32'h30000018, 32'hA5A50001,
                4'hF, 4, 32'h12345678, 32'h0, 1'b0, 4);
        run_txn("tmo", 1'b0, 32'h30000040, 32'h0, 4'h3,
                0, 32'h0, 32'hDEADBEEF, 1'b1, 16);
        run_txn("ack16", 1'b0, 32'h30000044, 32'h0, 4'hF,
                16, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 16);

        // Response backpressure with a second command waiting.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we = 1'b0;
        cmd_adr = 32'h30000008;
        cmd_sel = 4'hF;
        exp_q.push_back({1'b0, 32'h0000BEEF});
        @(negedge clk);
        chk("bp_cyc", {31'd0, wbm_cyc}, 32'd1);
        wbm_ack = 1'b1;
        wbm_dat_i = 32'h0000BEEF;
        cmd_we = 1'b1;
        cmd_adr = 32'h3000000C;
        cmd_dat = 32'h11223344;
        exp_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0000BEEF ||
                rsp_err !== 1'b0 || cmd_ready !== 1'b0 ||
                wbm_cyc !== 1'b0 || busy !== 1'b1) bad++;
            wbm_ack = 1'b1;
            wbm_dat_i = 32'hFFFFFFFF;
            @(negedge clk);
        end
        wbm_ack = 1'b0;
        chk("bp_hold", bad, 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (wbm_cyc === 1'b1) break;
            k++;
        end
        chk("bp_next_accept", {31'd0, wbm_cyc}, 32'd1);
        cmd_valid = 1'b0;
        chk("bp_next_adr", wbm_adr, 32'h3000000C);
        chk("bp_next_we", {31'd0, wbm_we}, 32'd1);
        wbm_ack = 1'b1;
        @(negedge clk);
        wbm_ack = 1'b0;
        drain("bp_drain");

        // Reset asserted while the bus cycle is open.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we = 1'b0;
        cmd_adr = 32'h30000020;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rb_pre_cyc", {31'd0, wbm_cyc}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rb_cyc", {31'd0, wbm_cyc}, 32'd0);
        chk("rb_stb", {31'd0, wbm_stb}, 32'd0);
        chk("rb_rsp", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rb_norsp", {31'd0, rsp_valid}, 32'd0);
        chk("rb_idle", {31'd0, busy}, 32'd0);
        run_txn("rb_after", 1'b0, 32'h30000024, 32'h0, 4'hF,
                2, 32'h0000CAFE, 32'h0000CAFE, 1'b0, 2);

        // Stray ack while idle.
        @(negedge clk);
        wbm_ack = 1'b1;
        wbm_dat_i = 32'h77777777;
        repeat (3) @(negedge clk);
        wbm_ack = 1'b0;
        chk("idle_ack_cyc", {31'd0, wbm_cyc}, 32'd0);
        chk("idle_ack_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);

        // Delayed read capture on the second instance.
        @(negedge clk);
        d1_cmd_valid = 1'b1;
        @(negedge clk);
        d1_cmd_valid = 1'b0;
        chk("d1_cyc", {31'd0, d1_cyc}, 32'd1);
        d1_ack = 1'b1;
        d1_dat_i = 32'h00000001;
        @(negedge clk);
        d1_ack = 1'b0;
        d1_dat_i = 32'h00000009;
        chk("d1_capture_cyc", {31'd0, d1_cyc}, 32'd0);
        chk("d1_capture_rv", {31'd0, d1_rsp_valid}, 32'd0);
        @(negedge clk);
        d1_dat_i = 32'h00000000;
        chk("d1_rv", {31'd0, d1_rsp_valid}, 32'd1);
        chk("d1_dat", d1_rsp_dat, 32'h00000009);
        chk("d1_err", {31'd0, d1_rsp_err}, 32'd0);
        @(negedge clk);
        chk("d1_done", {31'd0, d1_busy}, 32'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d",
                 n_checks, n_fail);
        $finish;
    end

endmodule
